// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Holds the opcode constants, the slice_op encodings, the FSM state enumeration,
// and small decode helpers used by serial_alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] SOP_AND  = 2'b00;
    localparam logic [1:0] SOP_OR   = 2'b01;
    localparam logic [1:0] SOP_SUM  = 2'b10;
    localparam logic [1:0] SOP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic [1:0] op;
    } slice_ctl_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

    // Arithmetic ops report carry/overflow from the MSB slice.
    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic slice_ctl_t op_decode(input logic [3:0] op);
        slice_ctl_t c;
        c = '{ainv: 1'b0, binv: 1'b0, op: SOP_AND};
        case (op)
            OP_OR:   c.op = SOP_OR;
            OP_ADD:  c.op = SOP_SUM;
            OP_SUB:  begin c.op = SOP_SUM; c.binv = 1'b1; end
            OP_SLT:  begin c.op = SOP_SUM; c.binv = 1'b1; end
            OP_NOR:  begin c.op = SOP_AND; c.ainv = 1'b1; c.binv = 1'b1; end
            default: c.op = SOP_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_operand_reg.sv
// WIDTH-bit load/shift register presenting one operand bit per cycle, LSB first.
// Ports: load_i captures d_i; shift_i moves the word right by one (zero fill);
// bit_o is the current least-significant bit.
module serial_operand_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end else if (shift_i) begin
            data_q <= {1'b0, data_q[WIDTH-1:1]};
        end
    end

    assign bit_o = data_q[0];

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer driving an external 1-bit ALU slice, one bit per cycle.
// Ports: start/opcode/a_in/b_in request; slice_* to/from the external slice;
// busy/done/result and zero/overflow/carry_out/illegal status.
module serial_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_ainv,
    output logic             slice_binv,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             illegal
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;
    logic             ill_q, ill_d;
    logic [3:0]       op_q, op_d;

    logic       load, shift;
    logic       a_bit, b_bit;
    logic       cin;
    logic       ovf_msb;
    slice_ctl_t ctl;

    serial_operand_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift), .d_i(a_in), .bit_o(a_bit)
    );

    serial_operand_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift), .d_i(b_in), .bit_o(b_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            ill_q    <= 1'b0;
            op_q     <= OP_AND;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            ill_q    <= ill_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        ill_d    = ill_q;
        op_d     = op_q;
        load     = 1'b0;
        shift    = 1'b0;
        cin      = 1'b0;
        ovf_msb  = 1'b0;
        ctl      = '{ainv: 1'b0, binv: 1'b0, op: SOP_AND};

        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_ainv = 1'b0;
        slice_binv = 1'b0;
        slice_cin  = 1'b0;
        slice_op   = SOP_AND;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    op_d     = opcode;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    result_d = '0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    cout_d   = 1'b0;
                    ill_d    = 1'b0;
                    if (op_legal(opcode)) begin
                        state_d = ST_EXEC;
                    end else begin
                        // Illegal ops skip execution and report result 0 with only illegal set.
                        ill_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                ctl = op_decode(op_q);
                // Bit 0 takes its carry-in from binv so SUB/SLT form the two's complement +1.
                cin = (idx_q == '0) ? ctl.binv : carry_q;

                slice_a    = a_bit;
                slice_b    = b_bit;
                slice_ainv = ctl.ainv;
                slice_binv = ctl.binv;
                slice_cin  = cin;
                slice_op   = ctl.op;

                shift            = 1'b1;
                carry_d          = slice_cout;
                result_d[idx_q]  = slice_result;
                idx_d            = idx_q + 1'b1;

                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    ovf_msb = cin ^ slice_cout;
                    if (op_is_arith(op_q)) begin
                        cout_d = slice_cout;
                        ovf_d  = ovf_msb;
                    end
                    // SLT: sign of the difference corrected for overflow; flags suppressed.
                    if (op_q == OP_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}}, slice_result ^ ovf_msb};
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                    end
                    zero_d = (result_d == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign slice_less = 1'b0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;
    assign carry_out  = cout_q;
    assign illegal    = ill_q;

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 opcode  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-006 a_in, b_in  in  WIDTH  operands; captured when start is accepted.
REQ-007 slice_a, slice_b  out  1  current operand bits to the 1-bit ALU slice.
REQ-008 slice_ainv, slice_binv, slice_cin, slice_less  out  1  slice controls.
REQ-009 slice_op  out  2  slice select: 00 and, 01 or, 10 sum, 11 less.
REQ-010 slice_result, slice_cout  in  1  slice outputs, combinational from slice_* outputs.
REQ-011 busy  out  1  high in EXEC and DONE.
REQ-012 done  out  1  one-cycle pulse; result and flags are valid.
REQ-013 result  out  WIDTH  operation result.
REQ-014 zero, overflow, carry_out, illegal  out  1  status flags.

Function
REQ-015 FSM states: IDLE, EXEC, DONE.
REQ-016 Transitions: IDLE->EXEC on start with a legal opcode; IDLE->DONE on start with an illegal opcode; EXEC->DONE after bit WIDTH-1; DONE->IDLE unconditionally.
REQ-017 On start acceptance: latch a_in, b_in and opcode; clear bit index; clear the result and all flags.
REQ-018 EXEC processes one bit per cycle, bit 0 first, for exactly WIDTH cycles.
REQ-019 slice_a and slice_b present operand bit[index]; slice_less is always 0.
REQ-020 Slice control mapping:
  AND: op 00, no inversion.
  OR: op 01.
  ADD: op 10.
  SUB: op 10, binv 1.
  SLT: op 10, binv 1.
  NOR: op 00, ainv 1, binv 1.
REQ-021 slice_cin: equals slice_binv at bit 0; otherwise the carry register; carry register loads slice_cout each EXEC cycle.
REQ-022 result[index] loads slice_result each EXEC cycle.
REQ-023 At the MSB cycle, for ADD/SUB/SLT only:
  carry_out = slice_cout.
  overflow = slice_cin XOR slice_cout.
REQ-024 For logic ops, carry_out and overflow are 0.
REQ-025 SLT: on the MSB cycle, result is replaced by {0..0, slice_result XOR overflow}; overflow and carry_out are reported as 0.
REQ-026 zero = (final result == 0), valid in DONE.
REQ-027 Illegal opcode: no EXEC cycles; DONE with result 0, illegal 1, other flags 0.
REQ-028 done is high only in DONE.
REQ-029 Latency: start sampled at edge t gives done high in the cycle following edge t+WIDTH+1 (legal opcode) or t+1 (illegal opcode).
REQ-030 start is ignored while busy; no queuing.
REQ-031 result and flags hold their DONE values through IDLE until the next start is accepted.
REQ-032 In IDLE, all slice_* outputs are 0.

Reset
REQ-033 rst_n low immediately forces IDLE, including mid-EXEC; the partial operation is discarded.
REQ-034 Reset values: busy 0, done 0, result 0, all flags 0, carry register 0, index 0, all slice_* outputs 0.
REQ-035 The first start after rst_n deasserts is accepted normally.

Structure
REQ-036 Package alu_seq_pkg holds the opcode constants, the slice_op encodings and the state enumeration.
REQ-037 One sub-module, serial_operand_reg: WIDTH-bit load/shift register; instantiated twice, for a and b.
REQ-038 The 1-bit ALU slice stays external and is connected through the slice_* ports.

Verification
REQ-039 ADD, WIDTH=8, 0x7F+0x01 -> result 0x80, overflow 1, carry_out 0, zero 0; done 9 cycles after start.
REQ-040 SUB 0x05-0x05 -> result 0x00, zero 1, carry_out 1, overflow 0.
REQ-041 Two operations:
  SLT a=0x80, b=0x01 -> result 0x01.
  SLT a=0x01, b=0x80 -> result 0x00.
REQ-042 NOR 0x0F, 0x33 -> result 0xC0, carry_out 0, overflow 0.
REQ-043 rst_n pulsed low during EXEC bit 3 -> busy 0 and result 0 immediately; a following ADD 0x01+0x01 -> result 0x02.
REQ-044 Two stimuli:
  start repeated while busy -> ignored, exactly one done.
  opcode 0101 -> done one cycle after start, illegal 1, result 0x00.
